// File: rtl/axi_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_ram_arbiter_if
// One AXI4 port bundle (AR, R, AW, W, B channels) for the RAM bus arbiter.
//   master modport : drives AR/AW/W payload+valid and R/B ready
//   slave  modport : drives AR/AW/W ready and R/B payload+valid
// Parameters: ADDR_W address width, DATA_W data width (strobe DATA_W/8),
//             ID_W transaction ID width.
// ---------------------------------------------------------------------------
interface axi_ram_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 64,
  parameter int ID_W   = 6
);
  // read address
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;
  // read data
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;
  // write address
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [ID_W-1:0]   awid;
  // write data
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast;
  // write response
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready,
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready,
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/axi_ram_arbiter.sv
// ---------------------------------------------------------------------------
// axi_ram_arbiter
// Two-master (s0 = host DMA, s1 = core/cache) to one-slave AXI4 arbiter in
// front of the SoC RAM bus. Read and write paths are arbitrated independently
// with their own round-robin pointer; one burst in flight per path.
// Responses are steered by the registered grant, never by ID.
// Ports:
//   clk     : single clock
//   aresetn : asynchronous active-low reset
//   s0, s1  : upstream masters (slave modport)
//   m       : downstream RAM bus (master modport)
// ---------------------------------------------------------------------------
module axi_ram_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 64,
  parameter int ID_W   = 6
) (
  input  logic      clk,
  input  logic      aresetn,
  axi_ram_if.slave  s0,
  axi_ram_if.slave  s1,
  axi_ram_if.master m
);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  // grant/pointer encoding: 0 = s0, 1 = s1; pointer names the preferred master
  logic [1:0] rd_state_q, rd_state_d;
  logic       rd_gnt_q, rd_gnt_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_state_q, wr_state_d;
  logic       wr_gnt_q, wr_gnt_d, wr_ptr_q, wr_ptr_d;

  // selected-master views of the request channels
  logic [ADDR_W-1:0] ar_addr_s, aw_addr_s;
  logic [7:0]        ar_len_s, aw_len_s;
  logic [2:0]        ar_size_s, aw_size_s;
  logic [1:0]        ar_burst_s, aw_burst_s;
  logic [ID_W-1:0]   ar_id_s, aw_id_s;
  logic [DATA_W-1:0] w_data_s;
  logic [STRB_W-1:0] w_strb_s;
  logic              w_valid_s, w_last_s, r_ready_s, b_ready_s;

  logic rd_addr_ph_s, rd_data_ph_s, wr_addr_ph_s, wr_data_ph_s, wr_resp_ph_s;
  logic r0_s, r1_s, w0_s, w1_s, b0_s, b1_s;

  assign ar_addr_s  = rd_gnt_q ? s1.araddr  : s0.araddr;
  assign ar_len_s   = rd_gnt_q ? s1.arlen   : s0.arlen;
  assign ar_size_s  = rd_gnt_q ? s1.arsize  : s0.arsize;
  assign ar_burst_s = rd_gnt_q ? s1.arburst : s0.arburst;
  assign ar_id_s    = rd_gnt_q ? s1.arid    : s0.arid;
  assign r_ready_s  = rd_gnt_q ? s1.rready  : s0.rready;
  assign aw_addr_s  = wr_gnt_q ? s1.awaddr  : s0.awaddr;
  assign aw_len_s   = wr_gnt_q ? s1.awlen   : s0.awlen;
  assign aw_size_s  = wr_gnt_q ? s1.awsize  : s0.awsize;
  assign aw_burst_s = wr_gnt_q ? s1.awburst : s0.awburst;
  assign aw_id_s    = wr_gnt_q ? s1.awid    : s0.awid;
  assign w_valid_s  = wr_gnt_q ? s1.wvalid  : s0.wvalid;
  assign w_data_s   = wr_gnt_q ? s1.wdata   : s0.wdata;
  assign w_strb_s   = wr_gnt_q ? s1.wstrb   : s0.wstrb;
  assign w_last_s   = wr_gnt_q ? s1.wlast   : s0.wlast;
  assign b_ready_s  = wr_gnt_q ? s1.bready  : s0.bready;

  assign rd_addr_ph_s = (rd_state_q == R_ADDR);
  assign rd_data_ph_s = (rd_state_q == R_DATA);
  assign wr_addr_ph_s = (wr_state_q == W_ADDR);
  assign wr_data_ph_s = (wr_state_q == W_DATA);
  assign wr_resp_ph_s = (wr_state_q == W_RESP);

  // per-master "this phase belongs to me" qualifiers
  assign r0_s = rd_data_ph_s & ~rd_gnt_q;
  assign r1_s = rd_data_ph_s &  rd_gnt_q;
  assign w0_s = wr_data_ph_s & ~wr_gnt_q;
  assign w1_s = wr_data_ph_s &  wr_gnt_q;
  assign b0_s = wr_resp_ph_s & ~wr_gnt_q;
  assign b1_s = wr_resp_ph_s &  wr_gnt_q;

  // Downstream AR/R: payload is zero outside the phase that owns it
  assign m.arvalid = rd_addr_ph_s;
  assign m.araddr  = rd_addr_ph_s ? ar_addr_s  : '0;
  assign m.arlen   = rd_addr_ph_s ? ar_len_s   : '0;
  assign m.arsize  = rd_addr_ph_s ? ar_size_s  : '0;
  assign m.arburst = rd_addr_ph_s ? ar_burst_s : '0;
  assign m.arid    = rd_addr_ph_s ? ar_id_s    : '0;
  assign m.rready  = rd_data_ph_s & r_ready_s;

  // Downstream AW/W/B
  assign m.awvalid = wr_addr_ph_s;
  assign m.awaddr  = wr_addr_ph_s ? aw_addr_s  : '0;
  assign m.awlen   = wr_addr_ph_s ? aw_len_s   : '0;
  assign m.awsize  = wr_addr_ph_s ? aw_size_s  : '0;
  assign m.awburst = wr_addr_ph_s ? aw_burst_s : '0;
  assign m.awid    = wr_addr_ph_s ? aw_id_s    : '0;
  assign m.wvalid  = wr_data_ph_s & w_valid_s;
  assign m.wdata   = wr_data_ph_s ? w_data_s : '0;
  assign m.wstrb   = wr_data_ph_s ? w_strb_s : '0;
  assign m.wlast   = wr_data_ph_s & w_last_s;
  assign m.bready  = wr_resp_ph_s & b_ready_s;

  // Upstream s0: only the granted master ever sees ready/valid
  assign s0.arready = rd_addr_ph_s & ~rd_gnt_q & m.arready;
  assign s0.rvalid  = r0_s & m.rvalid;
  assign s0.rdata   = r0_s ? m.rdata : '0;
  assign s0.rresp   = r0_s ? m.rresp : '0;
  assign s0.rlast   = r0_s & m.rlast;
  assign s0.rid     = r0_s ? m.rid : '0;
  assign s0.awready = wr_addr_ph_s & ~wr_gnt_q & m.awready;
  assign s0.wready  = w0_s & m.wready;
  assign s0.bvalid  = b0_s & m.bvalid;
  assign s0.bresp   = b0_s ? m.bresp : '0;
  assign s0.bid     = b0_s ? m.bid : '0;

  // Upstream s1
  assign s1.arready = rd_addr_ph_s & rd_gnt_q & m.arready;
  assign s1.rvalid  = r1_s & m.rvalid;
  assign s1.rdata   = r1_s ? m.rdata : '0;
  assign s1.rresp   = r1_s ? m.rresp : '0;
  assign s1.rlast   = r1_s & m.rlast;
  assign s1.rid     = r1_s ? m.rid : '0;
  assign s1.awready = wr_addr_ph_s & wr_gnt_q & m.awready;
  assign s1.wready  = w1_s & m.wready;
  assign s1.bvalid  = b1_s & m.bvalid;
  assign s1.bresp   = b1_s ? m.bresp : '0;
  assign s1.bid     = b1_s ? m.bid : '0;

  // Read FSM next state: arbitrate in IDLE, rotate pointer on the last beat
  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_ptr_d   = rd_ptr_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s0.arvalid || s1.arvalid) begin
          rd_gnt_d   = (s0.arvalid && s1.arvalid) ? rd_ptr_q : s1.arvalid;
          rd_state_d = R_ADDR;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_ADDR: begin
        if (m.arready) begin
          rd_state_d = R_DATA;
        end else begin
          rd_state_d = R_ADDR;
        end
      end
      R_DATA: begin
        if (m.rvalid && r_ready_s && m.rlast) begin
          rd_state_d = R_IDLE;
          rd_ptr_d   = ~rd_gnt_q;
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write FSM next state: same arbitration, pointer rotates on the B handshake
  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_ptr_d   = wr_ptr_q;
    case (wr_state_q)
      W_IDLE: begin
        if (s0.awvalid || s1.awvalid) begin
          wr_gnt_d   = (s0.awvalid && s1.awvalid) ? wr_ptr_q : s1.awvalid;
          wr_state_d = W_ADDR;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_ADDR: begin
        if (m.awready) begin
          wr_state_d = W_DATA;
        end else begin
          wr_state_d = W_ADDR;
        end
      end
      W_DATA: begin
        if (w_valid_s && m.wready && w_last_s) begin
          wr_state_d = W_RESP;
        end else begin
          wr_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (m.bvalid && b_ready_s) begin
          wr_state_d = W_IDLE;
          wr_ptr_d   = ~wr_gnt_q;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // State, grant and pointer registers; reset abandons any burst in flight
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      rd_gnt_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_state_q <= W_IDLE;
      wr_gnt_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_state_q <= wr_state_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end
endmodule
